// File: rtl/tc_bbuffer_pingpong.sv
// Double-buffered B-operand tile store: rows are scattered into tiles of one bank
// while whole tiles are served from the other bank.
module tc_bbuffer_pingpong #(
  parameter int N       = 16,
  parameter int K       = 16,
  parameter int TILE_N  = 4,
  parameter int TILE_K  = 4,
  parameter int DW_DATA = 32,
  localparam int ITER_N  = N / TILE_N,
  localparam int ITER_K  = K / TILE_K,
  localparam int N_TILE  = ITER_N * ITER_K,
  localparam int RW      = $clog2(K),
  localparam int PW      = $clog2(N_TILE) + 1,
  localparam int DW_ROW  = N * DW_DATA,
  localparam int DW_TILE = TILE_N * TILE_K * DW_DATA
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [RW-1:0]      wr_row,
  input  logic [DW_ROW-1:0]  wr_data,
  input  logic               rd_req_valid,
  output logic               rd_req_ready,
  input  logic [PW-1:0]      rd_ptr,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DW_TILE-1:0] rd_tile,
  input  logic               rd_release,
  output logic               wr_bank,
  output logic               rd_bank,
  output logic               err
);

  localparam int SW = TILE_N * DW_DATA;  // one tile sub-row
  localparam int TW = PW - 1;            // in-range tile index width

  // Handshakes: a write beat transfers when wr_valid && wr_ready, a tile request
  // when rd_req_valid && rd_req_ready; rd_tile transfers when rd_valid && rd_ready
  // and is held unchanged while rd_valid && !rd_ready.

  logic [DW_TILE-1:0] tiles [0:1][0:N_TILE-1];
  logic [K-1:0]       mask  [0:1];
  logic [1:0]         full;

  logic               wr_fire;
  logic               req_fire;
  logic               ptr_bad;
  logic [K-1:0]       mask_next;
  logic [TW-1:0]      tile_base;
  int                 sub_row;

  assign wr_ready     = !full[wr_bank];
  assign rd_req_ready = full[rd_bank] && (!rd_valid || rd_ready);

  always_comb begin
    wr_fire   = wr_valid && wr_ready;
    req_fire  = rd_req_valid && rd_req_ready;
    ptr_bad   = rd_ptr >= PW'(N_TILE);
    mask_next = mask[wr_bank] | (K'(1) << wr_row);
    tile_base = TW'((int'(wr_row) / TILE_K) * ITER_N);
    sub_row   = int'(wr_row) % TILE_K;
  end

  // Tile storage carries no reset; readability is governed by the row masks.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < ITER_N; c++) begin
        tiles[wr_bank][tile_base + TW'(c)][sub_row*SW +: SW] <= wr_data[c*SW +: SW];
      end
    end
  end

  // A written bank is never full and a released bank always is, so the write
  // and release paths below always touch different banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask[0]  <= '0;
      mask[1]  <= '0;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      rd_valid <= 1'b0;
      rd_tile  <= '0;
      err      <= 1'b0;
    end else begin
      if (wr_fire) begin
        mask[wr_bank] <= mask_next;
        if (&mask_next) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end

      if (rd_release) begin
        if (full[rd_bank]) begin
          mask[rd_bank] <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          err <= 1'b1;
        end
      end

      if (req_fire) begin
        rd_valid <= 1'b1;
        rd_tile  <= ptr_bad ? '0 : tiles[rd_bank][rd_ptr[TW-1:0]];
        if (ptr_bad) err <= 1'b1;
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tc_bbuffer_pingpong.sv
// Bench for tc_bbuffer_pingpong: directed scenarios plus random traffic checked
// against a row-major matrix model of both banks.
module tb_tc_bbuffer_pingpong;

  localparam int N = 16, K = 16, TILE_N = 4, TILE_K = 4, DW = 32;
  localparam int ITER_N = N / TILE_N, N_TILE = ITER_N * (K / TILE_K);
  localparam int RW = $clog2(K), PW = $clog2(N_TILE) + 1;
  localparam int DW_ROW = N * DW, DW_TILE = TILE_N * TILE_K * DW;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               wr_valid = 1'b0;
  logic               wr_ready;
  logic [RW-1:0]      wr_row = '0;
  logic [DW_ROW-1:0]  wr_data = '0;
  logic               rd_req_valid = 1'b0;
  logic               rd_req_ready;
  logic [PW-1:0]      rd_ptr = '0;
  logic               rd_valid;
  logic               rd_ready = 1'b1;
  logic [DW_TILE-1:0] rd_tile;
  logic               rd_release = 1'b0;
  logic               wr_bank;
  logic               rd_bank;
  logic               err;

  tc_bbuffer_pingpong dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_ptr(rd_ptr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_tile(rd_tile),
    .rd_release(rd_release), .wr_bank(wr_bank), .rd_bank(rd_bank), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: each bank is a plain K x N matrix plus a written-row set
  logic [DW-1:0]      m_mem  [2][K][N];
  logic [K-1:0]       m_rows [2];
  logic               m_full [2];
  int                 m_wb, m_rb;
  logic               m_rv, m_err;
  logic [DW_TILE-1:0] exp_q [$];

  task automatic check(input string tag, input logic [DW_TILE-1:0] obs,
                       input logic [DW_TILE-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW_TILE-1:0] exp_tile(input int b, input int t);
    logic [DW_TILE-1:0] v;
    v = '0;
    if (t < N_TILE) begin
      for (int r = 0; r < TILE_K; r++)
        for (int e = 0; e < TILE_N; e++)
          v[(r*TILE_N + e)*DW +: DW] = m_mem[b][(t / ITER_N)*TILE_K + r][(t % ITER_N)*TILE_N + e];
    end
    return v;
  endfunction

  task automatic model_clear();
    m_rows[0] = '0; m_rows[1] = '0;
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    m_wb = 0; m_rb = 0; m_rv = 1'b0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; rd_req_valid = 1'b0; rd_release = 1'b0; rd_ready = 1'b1;
  endtask

  // One clock: entered and left at the falling edge with inputs already driven.
  task automatic cycle();
    logic e_wr_ready, e_req_ready, wr_fire, req_fire, full_rb;
    #1;
    e_wr_ready  = !m_full[m_wb];
    e_req_ready = m_full[m_rb] && (!m_rv || rd_ready);
    check("wr_ready", wr_ready, e_wr_ready);
    check("rd_req_ready", rd_req_ready, e_req_ready);
    wr_fire  = wr_valid && e_wr_ready;
    req_fire = rd_req_valid && e_req_ready;
    full_rb  = m_full[m_rb];
    @(posedge clk);
    if (m_rv && rd_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (req_fire) begin
      exp_q.push_back(exp_tile(m_rb, int'(rd_ptr)));
      if (int'(rd_ptr) >= N_TILE) m_err = 1'b1;
    end
    m_rv = req_fire || (m_rv && !rd_ready);
    if (wr_fire) begin
      for (int j = 0; j < N; j++) m_mem[m_wb][wr_row][j] = wr_data[j*DW +: DW];
      m_rows[m_wb][wr_row] = 1'b1;
      if (&m_rows[m_wb]) begin
        m_full[m_wb] = 1'b1;
        m_wb ^= 1;
      end
    end
    if (rd_release) begin
      if (full_rb) begin
        m_rows[m_rb] = '0;
        m_full[m_rb] = 1'b0;
        m_rb ^= 1;
      end else begin
        m_err = 1'b1;
      end
    end
    #1;
    check("rd_valid", rd_valid, m_rv);
    if (m_rv && exp_q.size() > 0) check("rd_tile", rd_tile, exp_q[0]);
    check("wr_bank", wr_bank, m_wb[0]);
    check("rd_bank", rd_bank, m_rb[0]);
    check("err", err, m_err);
    @(negedge clk);
  endtask

  task automatic write_row(input int r, input logic [DW_ROW-1:0] d);
    wr_valid = 1'b1; wr_row = RW'(r); wr_data = d;
    cycle();
    wr_valid = 1'b0;
  endtask

  function automatic logic [DW_ROW-1:0] ramp_row(input int r);
    logic [DW_ROW-1:0] d;
    for (int j = 0; j < N; j++) d[j*DW +: DW] = DW'(r*16 + j);
    return d;
  endfunction

  function automatic logic [DW_ROW-1:0] rand_row();
    logic [DW_ROW-1:0] d;
    for (int j = 0; j < N; j++) d[j*DW +: DW] = $urandom();
    return d;
  endfunction

  task automatic request(input int p, input logic rdy);
    rd_req_valid = 1'b1; rd_ptr = PW'(p); rd_ready = rdy;
    cycle();
    rd_req_valid = 1'b0; rd_ready = 1'b1;
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    cycle();
    rd_release = 1'b0;
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_clear();
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_tile", rd_tile, '0);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_rd_req_ready", rd_req_ready, 1'b0);
    check("rst_wr_bank", wr_bank, 1'b0);
    check("rst_rd_bank", rd_bank, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    idle_inputs();
    @(negedge clk);
    async_reset();

    // 1: ramp fill of bank 0, read tile 5
    for (int r = 0; r < K; r++) write_row(r, ramp_row(r));
    request(5, 1'b1);
    check("t1_subrow0", rd_tile[4*DW-1:0], {32'd71, 32'd70, 32'd69, 32'd68});
    cycle();

    // 2: fill bank 1 so both are full, then release bank 0
    for (int r = 0; r < K; r++) write_row(r, rand_row());
    write_row(0, rand_row());
    release_bank();
    cycle();

    // 3: reverse-order fill of bank 0 with row 3 written twice
    for (int r = K - 1; r >= 3; r--) write_row(r, rand_row());
    write_row(3, {N{32'hAAAA_AAAA}});
    for (int r = 2; r >= 0; r--) write_row(r, rand_row());
    release_bank();
    request(0, 1'b1);
    check("t3_row3", rd_tile[3*TILE_N*DW +: DW], 32'hAAAA_AAAA);

    // 4: consumer stalls with a tile pending
    request(1, 1'b0);
    rd_req_valid = 1'b1; rd_ptr = PW'(2); rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    rd_ready = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // 5: out-of-range pointer, then a release with nothing full
    request(16, 1'b1);
    check("t5_tile_zero", rd_tile, '0);
    release_bank();
    release_bank();
    cycle();

    // random traffic on both sides
    for (int i = 0; i < 600; i++) begin
      wr_valid     = ($urandom_range(0, 1) == 1);
      wr_row       = RW'($urandom_range(0, K - 1));
      wr_data      = rand_row();
      rd_req_valid = ($urandom_range(0, 1) == 1);
      rd_ptr       = PW'($urandom_range(0, N_TILE + 1));
      rd_ready     = ($urandom_range(0, 3) != 0);
      rd_release   = ($urandom_range(0, 19) == 0);
      cycle();
    end
    idle_inputs();

    // 6: reset partway through a fill (possibly with a tile pending), then refill
    for (int r = 0; r < 7; r++) write_row(r, rand_row());
    rd_ready = 1'b0;
    async_reset();
    rd_ready = 1'b1;
    for (int r = 0; r < K; r++) write_row(r, rand_row());
    request($urandom_range(0, N_TILE - 1), 1'b1);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
